// File: rtl/l2_victim_buffer_pkg.sv
// Shared types for the L2 victim buffer: drain FSM states, entry layout and pointer sizing.
package l2_vb_types;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } vb_state_t;

    localparam int unsigned VB_TAG_W     = 27;
    localparam int unsigned VB_LINE_BITS = 256;
    localparam int unsigned VB_DEPTH     = 4;
    localparam int unsigned VB_PTR_W     = $clog2(VB_DEPTH);
    localparam int unsigned VB_CNT_W     = VB_PTR_W + 1;

    typedef struct packed {
        logic                    valid;
        logic [VB_TAG_W-1:0]     tag;
        logic [VB_LINE_BITS-1:0] data;
    } vb_entry_t;

    function automatic int unsigned vb_ptr_w(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/l2_victim_buffer_match.sv
// DEPTH-way tag comparator against the valid buffer entries; one-hot match plus hit flag.
module l2_vb_match #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 27
) (
    input  logic [DEPTH-1:0]       valid,
    input  logic [DEPTH*TAG_W-1:0] tags,
    input  logic [TAG_W-1:0]       tag,
    output logic [DEPTH-1:0]       match,
    output logic                   hit
);

    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (tags[i*TAG_W +: TAG_W] == tag);
        end
    end

    assign hit = |match;

endmodule

// File: rtl/l2_victim_buffer.sv
// Multi-entry L2 eviction write buffer: coalescing FIFO of dirty victim lines with
// same-cycle lookup and a WRITE/DONE drain FSM that re-writes lines updated mid-drain.
module l2_victim_buffer
    import l2_vb_types::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned OFFSET_W  = 5,
    parameter int unsigned TAG_W     = ADDR_W - OFFSET_W,
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned HIGH_WM   = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enq_valid,
    input  logic [TAG_W-1:0]         enq_tag,
    input  logic [LINE_BITS-1:0]     enq_data,
    output logic                     enq_ready,
    input  logic                     lkp_valid,
    input  logic [TAG_W-1:0]         lkp_tag,
    input  logic                     lkp_write,
    input  logic [LINE_BITS-1:0]     lkp_wdata,
    output logic                     lkp_hit,
    output logic [LINE_BITS-1:0]     lkp_rdata,
    input  logic                     drain_en,
    input  logic                     flush,
    output logic [ADDR_W-1:0]        pmem_address,
    output logic [LINE_BITS-1:0]     pmem_wdata,
    output logic                     pmem_write,
    input  logic                     pmem_resp,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PTR_W = vb_ptr_w(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] HIGH_WM_C = CNT_W'(HIGH_WM);

    logic [DEPTH-1:0]     valid_q;
    logic [TAG_W-1:0]     tag_q  [DEPTH];
    logic [LINE_BITS-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]     head_q, tail_q;
    logic [CNT_W-1:0]     count_q;
    logic                 redirty_q, redirty_d;
    vb_state_t            state_q, state_d;

    logic [DEPTH*TAG_W-1:0] tags_flat;
    logic [DEPTH-1:0]       enq_match, lkp_match;
    logic                   enq_hit, lkp_hit_raw;
    logic                   enq_acc, enq_coal, enq_alloc, lkp_upd, head_upd, pop;
    logic                   full_w, empty_w;

    always_comb begin
        tags_flat = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            tags_flat[i*TAG_W +: TAG_W] = tag_q[i];
        end
    end

    l2_vb_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_enq_match (
        .valid (valid_q),
        .tags  (tags_flat),
        .tag   (enq_tag),
        .match (enq_match),
        .hit   (enq_hit)
    );

    l2_vb_match #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_lkp_match (
        .valid (valid_q),
        .tags  (tags_flat),
        .tag   (lkp_tag),
        .match (lkp_match),
        .hit   (lkp_hit_raw)
    );

    assign full_w    = (count_q == DEPTH_C);
    assign empty_w   = (count_q == '0);
    assign enq_acc   = enq_valid && !full_w;
    assign enq_coal  = enq_acc && enq_hit;
    assign enq_alloc = enq_acc && !enq_hit;
    assign lkp_upd   = lkp_valid && lkp_write && lkp_hit_raw;
    assign head_upd  = (enq_coal && enq_match[head_q]) || (lkp_upd && lkp_match[head_q]);

    // A head update landing in DONE would otherwise be popped and lost; keep the head so it is re-written.
    assign pop = (state_q == DONE) && !redirty_q && !head_upd;

    always_comb begin
        state_d    = state_q;
        redirty_d  = redirty_q;
        pmem_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_w && (drain_en || flush || count_q >= HIGH_WM_C)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                pmem_write = 1'b1;
                if (head_upd) begin
                    redirty_d = 1'b1;
                end
                if (pmem_resp) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                redirty_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            redirty_q <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            redirty_q <= redirty_d;
            count_q   <= count_q + CNT_W'(enq_alloc) - CNT_W'(pop);
            if (enq_alloc) begin
                tail_q <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
        end
    end

    // Enqueue takes priority over a lookup write to the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (enq_alloc && tail_q == PTR_W'(i)) begin
                    valid_q[i] <= 1'b1;
                    tag_q[i]   <= enq_tag;
                    data_q[i]  <= enq_data;
                end else if (enq_coal && enq_match[i]) begin
                    data_q[i] <= enq_data;
                end else if (lkp_upd && lkp_match[i]) begin
                    data_q[i] <= lkp_wdata;
                end
                if (pop && head_q == PTR_W'(i)) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        lkp_rdata = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (lkp_valid && lkp_match[i]) begin
                lkp_rdata = lkp_rdata | data_q[i];
            end
        end
    end

    assign lkp_hit      = lkp_valid && lkp_hit_raw;
    assign pmem_address = {tag_q[head_q], {OFFSET_W{1'b0}}};
    assign pmem_wdata   = data_q[head_q];
    assign count        = count_q;
    assign empty        = empty_w;
    assign full         = full_w;
    assign enq_ready    = !full_w;

endmodule

// File: doc/l2_victim_buffer.md
Name: l2_victim_buffer

Overview:
- Parametrised multi-entry eviction write buffer for the L2 cache; successor to the single-entry EWB.
- Holds up to DEPTH dirty victim lines evicted by the L2 controller and drains them to physical memory in FIFO order.
- Serves same-cycle tag lookups so a miss on a buffered line returns buffered data, and write hits update the buffered copy.
- Adds coalescing, watermark/flush-driven draining, and re-write when a line is updated while it is being drained.

Parameters:
- ADDR_W, 32, physical address width.
- OFFSET_W, 5, line offset bits.
- TAG_W, ADDR_W-OFFSET_W, line tag width.
- LINE_BITS, 256, line width.
- DEPTH, 4, number of entries; power of two, at least 2.
- HIGH_WM, DEPTH-1, occupancy at or above which draining is forced.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enq_valid  in  1  victim line offered.
- enq_tag  in  TAG_W  victim line tag.
- enq_data  in  LINE_BITS  victim line data.
- enq_ready  out  1  entry accepted when enq_valid and enq_ready are both high.
- lkp_valid  in  1  lookup request.
- lkp_tag  in  TAG_W  lookup tag.
- lkp_write  in  1  write-hit update; qualified by lkp_valid.
- lkp_wdata  in  LINE_BITS  replacement line for a write hit.
- lkp_hit  out  1  stored valid entry matches lkp_tag (combinational).
- lkp_rdata  out  LINE_BITS  data of the matching entry (combinational); 0 on miss.
- drain_en  in  1  controller permits opportunistic draining.
- flush  in  1  level; drain until empty.
- pmem_address  out  ADDR_W  {head tag, OFFSET_W zeros}.
- pmem_wdata  out  LINE_BITS  head data.
- pmem_write  out  1  write request.
- pmem_resp  in  1  memory write complete.
- count  out  $clog2(DEPTH)+1  occupancy.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Behaviour:
- Reset (asynchronous, takes effect immediately regardless of state):
  - All valid bits and the redirty flag cleared; head=tail=0; count=0; FSM to IDLE.
  - Outputs: pmem_write=0, lkp_hit=0, empty=1, full=0, enq_ready=1.
  - A drain in progress is abandoned.
- Storage: circular FIFO of {valid, tag, data}.
  - head and tail wrap modulo DEPTH.
  - Invariant: at most one valid entry per tag.
- Enqueue (enq_valid & enq_ready):
  - If enq_tag matches a valid entry, that entry's data is overwritten in place. No allocation; count unchanged.
  - If the matched entry is the head during WRITE, the redirty flag is set.
  - Otherwise the line is written at tail; tail+1; count+1.
  - enq_ready = !full. A coalescing enqueue is still refused when full.
- Lookup:
  - Combinational compare against stored entries only; same-cycle enq data is not forwarded.
  - lkp_write on a hit replaces the entry's data at the clock edge.
  - A write hit on the head during WRITE sets redirty.
  - If lookup and enqueue update the same entry in one cycle, the enqueue wins.
- FSM:
  - IDLE:
    - Go to WRITE when !empty & (drain_en | flush | count>=HIGH_WM).
    - pmem_address/pmem_wdata are driven from head.
  - WRITE:
    - pmem_write=1; address and data are held stable from head storage.
    - Head data updates are allowed and set redirty; pmem_wdata then reflects the new data.
    - On pmem_resp, go to DONE.
  - DONE (one cycle):
    - If redirty: clear redirty, keep head, return to IDLE. The head is re-written later.
    - Else: invalidate head, head+1, count-1, return to IDLE.
- Simultaneous events:
  - Pop in DONE and allocating enqueue in the same cycle leave count unchanged.
  - enq_ready is not raised early by a same-cycle pop.
- Latency: one line write takes pmem latency + 2 cycles (WRITE entry, DONE); back-to-back drains have one IDLE cycle between them.
- Flush with empty=1 has no effect.
- Changing drain_en mid-WRITE does not abort the write.

Decomposition:
- Package l2_vb_types:
  - vb_state_t enum {IDLE, WRITE, DONE}.
  - vb_entry_t struct {valid, tag, data}.
  - Pointer/count width localparams.
- Sub-module l2_vb_match: combinational DEPTH-way tag compare giving a one-hot match vector and a hit flag. It is instantiated twice, once for enq_tag and once for lkp_tag.

Test Plan:
- Reset, then enq tag 0x0000010 data A with drain_en=0 -> count=1, lkp_tag 0x0000010 gives hit=1 and rdata=A, pmem_write stays 0.
- Enq 3 distinct tags with drain_en=0, DEPTH=4, HIGH_WM=3 -> forced drain; pmem_address=0x00000200 for tag 0x10; after resp and DONE, count=2.
- Enq tag 0x20 data B, then enq tag 0x20 data C -> count=1, lookup returns C, a single pmem write of C.
- During WRITE of head tag 0x30, lkp_write with data D -> after resp count is unchanged, a second write of 0x30 carries D, then count decrements.
- Fill to 4 entries -> full=1, enq_ready=0; a fifth enq is ignored; flush=1 drains all 4 in FIFO order, then empty=1.
- Deassert rst_n mid-WRITE -> pmem_write=0 and count=0 immediately, asynchronously; no pmem_write after release until a new enqueue.
